pbit_gibbs_array: RTL and testbench

Parametrised probabilistic-bit network: NUM_PBITS p-bits coupled through a run-time programmable symmetric-or-not weight matrix J and bias vector h, updated sequentially (Gibbs order 0..NUM_PBITS-1) by a single time-shared accumulator. Each p-bit's local field is computed, saturated, and compared against a per-update pseudo-random number. Successor to the fixed 3-node network: it generalises node count and width, adds a configuration port, run/stop control, and a sweep counter. Sits between the host config interface and downstream sample logging.

---
 rtl/pbit_pkg.sv | 39 +++
 rtl/pbit_rng.sv | 47 ++++
 rtl/pbit_gibbs_array.sv | 208 ++++++++++++++++++++
 tb/tb_pbit_gibbs_array.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pbit_pkg.sv
// -----------------------------------------------------------------------------
// pbit_pkg
// Shared definitions for the p-bit Gibbs sampler:
//   state_e      - controller states (IDLE, ACCUM, DECIDE)
//   LFSR_TAPS    - Galois feedback mask of the 32-bit random source
//   addr_width() - config address width for an N-node network (N*N + N entries)
//   sat_sym()    - symmetric saturation to +/-(2^(w-1)-1)
// -----------------------------------------------------------------------------
package pbit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // J occupies the first N*N addresses, h the following N.
    function automatic int addr_width(input int n);
        return $clog2(n * n + n);
    endfunction

    // Clamp to a symmetric range so that +max and -max are equally reachable;
    // the most negative code is never produced.
    function automatic logic signed [31:0] sat_sym(input logic signed [31:0] v,
                                                   input int                 w);
        logic signed [31:0] maxv;
        maxv = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (v > maxv) begin
            return maxv;
        end
        if (v < -maxv) begin
            return -maxv;
        end
        return v;
    endfunction

endpackage

// File: rtl/pbit_rng.sv
// -----------------------------------------------------------------------------
// pbit_rng
// 32-bit Galois LFSR (right-shifting, feedback mask LFSR_TAPS). Advances one
// step per cycle while adv is high; the low W bits are the random number.
// A zero SEED would lock the register, so it is replaced by 1.
// Ports:
//   CLK, RST  - clock, synchronous active-high reset (loads the seed)
//   adv       - step enable
//   rnd       - low W bits of the current LFSR state
// -----------------------------------------------------------------------------
module pbit_rng #(
    parameter int          W    = 8,
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         adv,
    output logic [W-1:0] rnd
);
    import pbit_pkg::*;

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {1'b0, lfsr_q[31:1]};
            if (lfsr_q[0]) begin
                lfsr_d = lfsr_d ^ LFSR_TAPS;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd = lfsr_q[W-1:0];

endmodule

// File: rtl/pbit_gibbs_array.sv
// -----------------------------------------------------------------------------
// pbit_gibbs_array
// Network of NUM_PBITS probabilistic bits updated in sequential Gibbs order by
// one time-shared accumulator. For each p-bit i the local field
//   I_i = h[i] + sum_{j != i} J[i][j] * m_j      (m_j in {-1,+1})
// is built over N cycles by add/subtract (no multiplier), saturated, and
// compared with a fresh signed random number to choose the new m_i.
// Ports:
//   CLK, RST     - clock, synchronous active-high reset
//   run          - level; starts a sweep from IDLE, continues back-to-back
//   cfg_we       - weight/bias write strobe (honoured only in IDLE)
//   cfg_addr     - i*N+j -> J[i][j];  N*N+i -> h[i]; others ignored
//   cfg_data     - signed W-bit value to write
//   states       - bit i set means m_i = +1
//   busy         - controller is not idle
//   sweep_done   - one-cycle pulse with the last p-bit update of a sweep
//   sweep_count  - completed sweeps, wrapping at 16 bits
// -----------------------------------------------------------------------------
module pbit_gibbs_array #(
    parameter int          NUM_PBITS = 4,
    parameter int          W         = 8,
    parameter logic [31:0] SEED      = 32'h1
) (
    input  logic                                               CLK,
    input  logic                                               RST,
    input  logic                                               run,
    input  logic                                               cfg_we,
    input  logic [$clog2(NUM_PBITS*NUM_PBITS+NUM_PBITS)-1:0]   cfg_addr,
    input  logic [W-1:0]                                       cfg_data,
    output logic [NUM_PBITS-1:0]                               states,
    output logic                                               busy,
    output logic                                               sweep_done,
    output logic [15:0]                                        sweep_count
);
    import pbit_pkg::*;

    localparam int N       = NUM_PBITS;
    localparam int NN      = N * N;
    localparam int NUM_ENT = NN + N;
    localparam int ADDR_W  = addr_width(N);
    localparam int IDX_W   = $clog2(N);
    // One sign bit of headroom over N terms of W bits: the sum never wraps.
    localparam int ACC_W   = W + $clog2(N) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);
    localparam logic signed [W-1:0] MAXV     = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] NEG_MAXV = {1'b1, {(W-2){1'b0}}, 1'b1};

    // Weight/bias storage and controller state.
    logic signed [W-1:0]     mem_q [NUM_ENT];
    logic signed [W-1:0]     mem_d [NUM_ENT];
    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        i_q, i_d;
    logic [IDX_W-1:0]        j_q, j_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [N-1:0]            states_q, states_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [15:0]             cnt_q, cnt_d;

    // Datapath intermediates.
    logic [ADDR_W-1:0]       j_addr;
    logic [ADDR_W-1:0]       h_addr;
    logic signed [W-1:0]     j_val;
    logic signed [W-1:0]     h_val;
    logic signed [ACC_W-1:0] j_ext;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [31:0]      isat_full;
    logic signed [W-1:0]     isat;
    logic [W-1:0]            rnd;
    logic signed [W-1:0]     rnd_s;
    logic                    m_new;
    logic                    cfg_ok;
    logic                    rng_adv;

    // Random source steps exactly once per DECIDE cycle.
    assign rng_adv = (state_q == DECIDE);

    pbit_rng #(
        .W    (W),
        .SEED (SEED)
    ) u_rng (
        .CLK (CLK),
        .RST (RST),
        .adv (rng_adv),
        .rnd (rnd)
    );

    // Accumulate stage: fetch J[i][j] and h[i], signed add/subtract by m_j.
    always_comb begin
        j_addr   = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(j_q);
        h_addr   = ADDR_W'(NN) + ADDR_W'(i_q);
        j_val    = mem_q[j_addr];
        h_val    = mem_q[h_addr];
        j_ext    = ACC_W'(j_val);
        if (j_q == i_q) begin
            term = '0;
        end else if (states_q[j_q]) begin
            term = j_ext;
        end else begin
            term = -j_ext;
        end
        acc_base = (j_q == '0) ? ACC_W'(h_val) : acc_q;
        acc_sum  = acc_base + term;
    end

    // Decide stage: saturate the field; outside the open range the outcome is
    // forced, inside it the random draw sets the probability.
    always_comb begin
        isat_full = sat_sym(32'(acc_q), W);
        isat      = isat_full[W-1:0];
        rnd_s     = rnd;
        if (isat >= MAXV) begin
            m_new = 1'b1;
        end else if (isat <= NEG_MAXV) begin
            m_new = 1'b0;
        end else begin
            m_new = (isat > rnd_s);
        end
    end

    assign cfg_ok = cfg_we && (cfg_addr <= LAST_ADDR);

    always_comb begin
        mem_d    = mem_q;
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        acc_d    = acc_q;
        states_d = states_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // A write in the same cycle as run lands before the first fetch.
                if (cfg_ok) begin
                    mem_d[cfg_addr] = cfg_data;
                end
                if (run) begin
                    state_d = ACCUM;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            ACCUM: begin
                acc_d = acc_sum;
                if (j_q == LAST_IDX) begin
                    j_d     = '0;
                    state_d = DECIDE;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DECIDE: begin
                // Written back immediately so later p-bits see the new value.
                states_d[i_q] = m_new;
                if (i_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    i_d     = '0;
                    state_d = run ? ACCUM : IDLE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NUM_ENT; k++) begin
                mem_q[k] <= '0;
            end
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            acc_q    <= '0;
            states_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            acc_q    <= acc_d;
            states_q <= states_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign states      = states_q;
    assign busy        = busy_q;
    assign sweep_done  = done_q;
    assign sweep_count = cnt_q;

endmodule

// File: tb/tb_pbit_gibbs_array.sv
// -----------------------------------------------------------------------------
// tb_pbit_gibbs_array
// Directed bench for the 4-node, 8-bit configuration. Deterministic scenarios
// use fields at the saturation limits; the unbiased network is checked for a
// balanced ones fraction.
// -----------------------------------------------------------------------------
module tb_pbit_gibbs_array;

    logic        CLK;
    logic        RST;
    logic        run;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [3:0]  states;
    logic        busy;
    logic        sweep_done;
    logic [15:0] sweep_count;

    int checks;
    int errors;

    pbit_gibbs_array #(
        .NUM_PBITS (4),
        .W         (8),
        .SEED      (32'h1)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .run         (run),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .states      (states),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .sweep_count (sweep_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        run    = 1'b0;
        cfg_we = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // Starts one sweep and returns the cycle (after the run edge) of sweep_done.
    task automatic one_sweep(output int done_at);
        run = 1'b1;
        tick();
        run = 1'b0;
        done_at = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (sweep_done) begin
                done_at = c;
                break;
            end
        end
    endtask

    task automatic cfg_bias();
        cfg_write(5'd16, 8'd127);
        cfg_write(5'd17, 8'h81);
        cfg_write(5'd18, 8'd127);
        cfg_write(5'd19, 8'h81);
    endtask

    task automatic test_reset();
        run    = 1'b1;
        RST    = 1'b1;
        cfg_we = 1'b0;
        tick();
        tick();
        checks++; if (states !== 4'b0000) begin errors++; $display("FAIL reset_states got %b want 0000", states); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", sweep_done); end
        checks++; if (sweep_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sweep_count); end
        RST = 1'b0;
        run = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_bias();
        int got;
        do_reset();
        cfg_bias();
        run = 1'b1;
        tick();
        run = 1'b0;
        got = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 4) begin
                checks++; if (states !== 4'b0000) begin errors++; $display("FAIL bias_c4_states got %b want 0000", states); end
            end
            if (c == 5) begin
                checks++; if (states !== 4'b0001) begin errors++; $display("FAIL bias_c5_states got %b want 0001", states); end
            end
            if (sweep_done) begin
                got = c;
                break;
            end
        end
        checks++; if (got !== 20) begin errors++; $display("FAIL bias_done_cycle got %0d want 20", got); end
        checks++; if (states !== 4'b0101) begin errors++; $display("FAIL bias_states got %b want 0101", states); end
        checks++; if (sweep_count !== 16'd1) begin errors++; $display("FAIL bias_count got %0d want 1", sweep_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bias_busy_end got %b want 0", busy); end
        tick();
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL bias_done_pulse got %b want 0", sweep_done); end
    endtask

    task automatic test_chain();
        int got;
        do_reset();
        cfg_write(5'd16, 8'd127);
        cfg_write(5'd4,  8'd127);
        cfg_write(5'd9,  8'd127);
        cfg_write(5'd14, 8'd127);
        one_sweep(got);
        checks++; if (got !== 20) begin errors++; $display("FAIL chain_done_cycle got %0d want 20", got); end
        checks++; if (states !== 4'b1111) begin errors++; $display("FAIL chain_up_states got %b want 1111", states); end
        cfg_write(5'd16, 8'h81);
        one_sweep(got);
        checks++; if (states !== 4'b0000) begin errors++; $display("FAIL chain_down_states got %b want 0000", states); end
        checks++; if (sweep_count !== 16'd2) begin errors++; $display("FAIL chain_count got %0d want 2", sweep_count); end
    endtask

    task automatic test_diag_guard();
        int got;
        do_reset();
        cfg_write(5'd0,  8'h81);
        cfg_write(5'd16, 8'd127);
        cfg_write(5'd17, 8'h81);
        cfg_write(5'd18, 8'h81);
        cfg_write(5'd19, 8'h81);
        run = 1'b1;
        tick();
        run = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL guard_busy got %b want 1", busy); end
        // Attempted write while the sweep is running must be dropped.
        cfg_we   = 1'b1;
        cfg_addr = 5'd17;
        cfg_data = 8'd127;
        got = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            cfg_we = 1'b0;
            if (sweep_done) begin
                got = c;
                break;
            end
        end
        checks++; if (got !== 20) begin errors++; $display("FAIL guard_done_cycle got %0d want 20", got); end
        checks++; if (states !== 4'b0001) begin errors++; $display("FAIL diag_states_s1 got %b want 0001", states); end
        cfg_write(5'd20, 8'd127);
        for (int s = 2; s <= 4; s++) begin
            one_sweep(got);
            checks++; if (states !== 4'b0001) begin errors++; $display("FAIL diag_states_s%0d got %b want 0001", s, states); end
        end
        checks++; if (sweep_count !== 16'd4) begin errors++; $display("FAIL guard_count got %0d want 4", sweep_count); end
    endtask

    task automatic test_back_to_back();
        int n_done;
        int done_at [4];
        do_reset();
        cfg_bias();
        for (int k = 0; k < 4; k++) done_at[k] = -1;
        n_done = 0;
        run = 1'b1;
        tick();
        for (int c = 1; c <= 90; c++) begin
            tick();
            if (c == 70) run = 1'b0;
            if (sweep_done) begin
                if (n_done < 4) done_at[n_done] = c;
                n_done++;
            end
            if (c == 79) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_c79 got %b want 1", busy); end
            end
            if (c == 80) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_c80 got %b want 0", busy); end
            end
        end
        checks++; if (n_done !== 4) begin errors++; $display("FAIL b2b_num_done got %0d want 4", n_done); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (done_at[k] !== 20 * (k + 1)) begin errors++; $display("FAIL b2b_done%0d_cycle got %0d want %0d", k, done_at[k], 20 * (k + 1)); end
        end
        checks++; if (sweep_count !== 16'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", sweep_count); end
        checks++; if (states !== 4'b0101) begin errors++; $display("FAIL b2b_states got %b want 0101", states); end
    endtask

    task automatic test_rst_mid();
        int seen;
        do_reset();
        cfg_bias();
        run = 1'b1;
        tick();
        for (int c = 1; c <= 9; c++) tick();
        checks++; if (states !== 4'b0001) begin errors++; $display("FAIL rstmid_pre_states got %b want 0001", states); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got %b want 1", busy); end
        RST = 1'b1;
        run = 1'b0;
        tick();
        RST = 1'b0;
        checks++; if (states !== 4'b0000) begin errors++; $display("FAIL rstmid_states got %b want 0000", states); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", sweep_done); end
        checks++; if (sweep_count !== 16'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", sweep_count); end
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (sweep_done || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_activity got %0d want 0", seen); end
    endtask

    // Relies on the reset in the previous scenario having cleared J and h.
    task automatic test_stats();
        int n;
        int ones [4];
        for (int b = 0; b < 4; b++) ones[b] = 0;
        n = 0;
        run = 1'b1;
        for (int c = 0; c < 21000 && n < 1000; c++) begin
            tick();
            if (sweep_done) begin
                n++;
                for (int b = 0; b < 4; b++) ones[b] += int'(states[b]);
                if (n == 999) run = 1'b0;
            end
        end
        run = 1'b0;
        for (int c = 0; c < 30 && busy; c++) tick();
        checks++; if (n !== 1000) begin errors++; $display("FAIL stats_sweeps got %0d want 1000", n); end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (ones[b] < 450 || ones[b] > 550) begin
                errors++;
                $display("FAIL stats_bit%0d_ones got %0d want 450..550", b, ones[b]);
            end
        end
        checks++; if (sweep_count !== 16'd1000) begin errors++; $display("FAIL stats_count got %0d want 1000", sweep_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stats_busy_end got %b want 0", busy); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        RST      = 1'b1;
        run      = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        test_reset();
        test_bias();
        test_chain();
        test_diag_guard();
        test_back_to_back();
        test_rst_mid();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
